riscv_stage_sequencer: RTL and testbench

Parametrised control sequencer for the multi-cycle RV32I core. It generates the one-hot stage strobes that drive the decoder, ALU, branch unit and memory controller. Compared with the fixed four-state controller, it adds:
- a fetch valid/ack handshake;
- a dedicated memory-wait state that honours both read and write acknowledges;
- a configurable memory timeout with a sticky fault;
- debug resume from halt;
- a retired-instruction counter.

---
 rtl/riscv_stage_sequencer.sv | 106 ++++++++++
 tb/tb_riscv_stage_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_stage_sequencer.sv
// riscv_stage_sequencer: multi-cycle RV32I stage sequencer emitting one-hot stage strobes
// Ports:
//   clk, rst_n                 clock (rising edge) and asynchronous active-low reset
//   imem_req / imem_ack        instruction fetch request and acknowledge
//   is_load/is_store/is_ebreak decoded instruction class, sampled in EXECUTE
//   dmem_rd_ack / dmem_wr_ack  data memory read/write completion
//   resume                     debug resume, honoured only in HALT
//   fetch/decode/execute/write_back  one-hot stage strobes
//   mem_wait                   waiting on data memory
//   rf_we                      register-file write strobe
//   retire / instret           retire pulse and retired-instruction count
//   halted / mem_fault         HALT state and sticky memory-timeout fault
// Parameters: CNT_W (instret width), TIMEOUT (MEM_WAIT cycle limit, 0 = no limit)
// Macro: SEQ_INSTRET_EN enables the instret counter; otherwise instret is tied to 0.
module riscv_stage_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_ebreak,
  input  logic             dmem_rd_ack,
  input  logic             dmem_wr_ack,
  input  logic             resume,
  output logic             fetch,
  output logic             decode,
  output logic             execute,
  output logic             write_back,
  output logic             mem_wait,
  output logic             rf_we,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic             mem_fault
);
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM_WAIT, S_WRITE_BACK, S_HALT, S_FAULT
  } state_t;
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_t        state_q, state_d;
  logic          store_q, store_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          hit, expired;
  // store_q selects which data ack ends MEM_WAIT and suppresses rf_we
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    wcnt_d  = wcnt_q;
    hit     = store_q ? dmem_wr_ack : dmem_rd_ack;
    // wcnt_q holds the number of completed wait cycles, so TIMEOUT-1 marks the last allowed one
    expired = (TIMEOUT > 0) && (32'(wcnt_q) == 32'(TIMEOUT - 1));
    case (state_q)
      S_FETCH:      state_d = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE:     state_d = S_EXECUTE;
      S_EXECUTE: begin
        store_d = !is_ebreak && !is_load && is_store;
        wcnt_d  = '0;
        state_d = is_ebreak ? S_HALT : (is_load || is_store) ? S_MEM_WAIT : S_WRITE_BACK;
      end
      S_MEM_WAIT: begin
        wcnt_d  = hit ? wcnt_q : wcnt_q + 1'b1;
        state_d = hit ? S_WRITE_BACK : expired ? S_FAULT : S_MEM_WAIT;
      end
      S_WRITE_BACK: state_d = S_FETCH;
      S_HALT:       state_d = resume ? S_FETCH : S_HALT;
      S_FAULT:      state_d = S_FAULT;
      default:      state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      store_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      wcnt_q  <= wcnt_d;
    end
  end
  assign imem_req   = state_q == S_FETCH;
  assign fetch      = state_q == S_FETCH;
  assign decode     = state_q == S_DECODE;
  assign execute    = state_q == S_EXECUTE;
  assign mem_wait   = state_q == S_MEM_WAIT;
  assign write_back = state_q == S_WRITE_BACK;
  assign halted     = state_q == S_HALT;
  assign mem_fault  = state_q == S_FAULT;
  assign rf_we      = write_back && !store_q;
  // ebreak retires in EXECUTE itself, the only output that looks at a live input
  assign retire     = write_back || (execute && is_ebreak);
`ifdef SEQ_INSTRET_EN
  logic [CNT_W-1:0] instret_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else if (retire) instret_q <= instret_q + CNT_W'(1);
  end
  assign instret = instret_q;
`else
  assign instret = '0;
`endif
endmodule

// File: tb/tb_riscv_stage_sequencer.sv
// tb_riscv_stage_sequencer: directed self-checking bench for riscv_stage_sequencer
module tb_riscv_stage_sequencer;
  logic clk = 1'b0;
  logic rst_n, imem_req, imem_ack, is_load, is_store, is_ebreak;
  logic dmem_rd_ack, dmem_wr_ack, resume;
  logic fetch, decode, execute, write_back, mem_wait, rf_we, retire, halted, mem_fault;
  logic [3:0] instret;
  int total = 0, passes = 0, n = 0;
  // {imem_req,fetch,decode,execute,mem_wait,write_back,rf_we,retire,halted,mem_fault}
  localparam logic [9:0] O_F = 10'b1100000000, O_D = 10'b0010000000, O_E = 10'b0001000000,
    O_EB = 10'b0001000100, O_MW = 10'b0000100000, O_WBR = 10'b0000011100,
    O_WBS = 10'b0000010100, O_H = 10'b0000000010, O_FLT = 10'b0000000001;
  riscv_stage_sequencer #(.CNT_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack),
    .is_load(is_load), .is_store(is_store), .is_ebreak(is_ebreak),
    .dmem_rd_ack(dmem_rd_ack), .dmem_wr_ack(dmem_wr_ack), .resume(resume),
    .fetch(fetch), .decode(decode), .execute(execute), .write_back(write_back),
    .mem_wait(mem_wait), .rf_we(rf_we), .retire(retire), .instret(instret),
    .halted(halted), .mem_fault(mem_fault)
  );
  initial forever #5 clk = ~clk;
  function automatic logic [9:0] obs();
    return {imem_req, fetch, decode, execute, mem_wait, write_back, rf_we, retire, halted, mem_fault};
  endfunction
  function automatic logic [3:0] ei(int k);
`ifdef SEQ_INSTRET_EN
    return 4'(k);
`else
    return 4'(k * 0);
`endif
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [9:0] got, logic [9:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %b expected %b", tag, got, exp);
  endtask
  task automatic chk_cnt(string tag);
    total++;
    assert (instret === ei(n)) passes++;
    else $error("FAIL %s: instret got %0d expected %0d", tag, instret, ei(n));
  endtask
  task automatic alu_instr();
    imem_ack = 1'b1;
    chk("alu_fetch", obs(), O_F);
    tick();
    imem_ack = 1'b0;
    chk("alu_decode", obs(), O_D);
    tick();
    chk("alu_execute", obs(), O_E);
    tick();
    chk("alu_wb", obs(), O_WBR);
    tick();
    n++;
    chk_cnt("alu_instret");
  endtask
  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; is_load = 1'b0; is_store = 1'b0; is_ebreak = 1'b0;
    dmem_rd_ack = 1'b0; dmem_wr_ack = 1'b0; resume = 1'b0;
    tick();
    tick();
    chk("reset_state", obs(), O_F);
    chk_cnt("reset_instret");
    rst_n = 1'b1;
    alu_instr();
    // fetch stall: imem_req held for cycles 0..3, DECODE on cycle 4
    chk("stall_c0", obs(), O_F);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("stall_fetch", obs(), O_F);
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("stall_decode", obs(), O_D);
    // load (store also asserted; load wins) with spurious write ack
    is_load = 1'b1; is_store = 1'b1;
    tick();
    chk("ld_execute", obs(), O_E);
    tick();
    is_load = 1'b0; is_store = 1'b0;
    chk("ld_wait1", obs(), O_MW);
    dmem_wr_ack = 1'b1;
    tick();
    dmem_wr_ack = 1'b0;
    chk("ld_wait2_wr_ignored", obs(), O_MW);
    dmem_rd_ack = 1'b1;
    tick();
    dmem_rd_ack = 1'b0;
    chk("ld_wb", obs(), O_WBR);
    chk_cnt("ld_instret_before");
    tick();
    n++;
    chk_cnt("ld_instret_after");
    // store with no ack: fault after 4 wait cycles
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    is_store = 1'b1;
    tick();
    tick();
    is_store = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("st_timeout_wait", obs(), O_MW);
      tick();
    end
    chk("st_fault", obs(), O_FLT);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("fault_ignores_resume", obs(), O_FLT);
    chk_cnt("fault_instret");
    rst_n = 1'b0;
    #1;
    chk("async_reset_now", obs(), O_F);
    n = 0;
    chk_cnt("async_reset_instret");
    tick();
    rst_n = 1'b1;
    // store with write ack on wait cycle 4, read ack ignored
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    is_store = 1'b1;
    tick();
    tick();
    is_store = 1'b0;
    chk("st2_wait1", obs(), O_MW);
    tick();
    dmem_rd_ack = 1'b1;
    tick();
    dmem_rd_ack = 1'b0;
    chk("st2_wait3_rd_ignored", obs(), O_MW);
    tick();
    dmem_wr_ack = 1'b1;
    chk("st2_wait4", obs(), O_MW);
    tick();
    dmem_wr_ack = 1'b0;
    chk("st2_wb_no_rfwe", obs(), O_WBS);
    tick();
    n++;
    chk_cnt("st2_instret");
    chk("st2_back_to_fetch", obs(), O_F);
    // ebreak has priority over load; retire in EXECUTE
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    is_ebreak = 1'b1; is_load = 1'b1;
    tick();
    chk("eb_execute_retire", obs(), O_EB);
    chk_cnt("eb_instret_before");
    tick();
    is_ebreak = 1'b0; is_load = 1'b0;
    n++;
    chk("eb_halted", obs(), O_H);
    chk_cnt("eb_instret_after");
    imem_ack = 1'b1; dmem_rd_ack = 1'b1; dmem_wr_ack = 1'b1;
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("eb_hold", obs(), O_H);
    end
    imem_ack = 1'b0; dmem_rd_ack = 1'b0; dmem_wr_ack = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("eb_resume_fetch", obs(), O_F);
    chk_cnt("eb_instret_once");
    // counter wrap with CNT_W=4
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 16; i++) alu_instr();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
